// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB round-robin arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

endpackage

// File: rtl/apb_rr_arbiter_rr.sv
// Combinational round-robin picker: the first requester after last_grant (wrapping) wins.
module apb_rr_arbiter_rr #(
    parameter int NREQ = 4,
    parameter int LW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last_grant,
    output logic [NREQ-1:0] gnt,
    output logic [LW-1:0]   gnt_idx,
    output logic            any
);

    assign any = |req;

    // Walk offsets from farthest to nearest so the nearest valid requester overwrites the rest.
    always_comb begin
        gnt     = '0;
        gnt_idx = last_grant;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last_grant) + k) % NREQ]) begin
                gnt                                  = '0;
                gnt[(int'(last_grant) + k) % NREQ]   = 1'b1;
                gnt_idx                              = LW'((int'(last_grant) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Shares one APB bus among NREQ requesters: round-robin grant, IDLE/SETUP/ACCESS
// sequencing, per-requester response pulse and a pready timeout.
import apb_pkg::*;

module apb_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AW-1:0]     paddr,
    output logic [DW-1:0]     pwdata,
    input  logic [DW-1:0]     prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int LW = $clog2(NREQ);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_e      state_q, state_d;
    logic [LW-1:0]   last_grant_q, owner_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [NREQ-1:0] arb_req, arb_gnt, owner_oh;
    logic [LW-1:0]   arb_idx;
    logic            arb_any;
    logic            done, timeout_hit, accept;

    // The owner of the transfer still in ACCESS may not win the re-arbitration it completes.
    assign owner_oh = NREQ'(1) << owner_q;
    assign arb_req  = (state_q == ACCESS) ? (req_valid & ~owner_oh) : req_valid;

    apb_rr_arbiter_rr #(.NREQ(NREQ), .LW(LW)) u_rr (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    assign done        = (state_q == ACCESS) && pready;
    assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !pready
                         && (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign accept      = ((state_q == IDLE) || done) && arb_any;
    assign req_ready   = (accept && prst) ? arb_gnt : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (done)             state_d = accept ? SETUP : IDLE;
                else if (timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q      <= IDLE;
            last_grant_q <= LW'(NREQ - 1);
            owner_q      <= '0;
            tmo_cnt_q    <= '0;
            psel         <= 1'b0;
            penable      <= 1'b0;
            pwrite       <= 1'b0;
            paddr        <= '0;
            pwdata       <= '0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;

            if (accept) begin
                last_grant_q <= arb_idx;
                owner_q      <= arb_idx;
                tmo_cnt_q    <= '0;
                psel         <= 1'b1;
                penable      <= 1'b0;
                pwrite       <= req_write[arb_idx];
                paddr        <= req_addr[int'(arb_idx)*AW +: AW];
                pwdata       <= req_write[arb_idx] ? req_wdata[int'(arb_idx)*DW +: DW] : '0;
            end else if (state_q == SETUP) begin
                tmo_cnt_q <= '0;
                penable   <= 1'b1;
            end else if (done || timeout_hit) begin
                psel    <= 1'b0;
                penable <= 1'b0;
            end else if (state_q == ACCESS) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            // Response for the transfer that finished (or was abandoned) this cycle.
            if (done) begin
                rsp_valid <= owner_oh;
                rsp_err   <= pslverr;
                rsp_rdata <= pwrite ? '0 : prdata;
            end else if (timeout_hit) begin
                rsp_valid <= owner_oh;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Randomized bench for apb_rr_arbiter with a transaction-level reference model.
module tb_apb_rr_arbiter;

    localparam int NREQ = 4, AW = 32, DW = 32, TIMEOUT = 16;

    logic                pclk = 1'b0;
    logic                prst;
    logic [NREQ-1:0]     req_valid, req_write, req_ready, rsp_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [DW-1:0]       rsp_rdata, pwdata, prdata;
    logic                rsp_err, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0]       paddr;

    int n_checks = 0;
    int n_fail   = 0;
    int last_gnt;

    always #5 pclk = ~pclk;

    apb_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk      (pclk),
        .prst      (prst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Rotating priority: nearest valid requester after the last winner.
    function automatic int rr_pick(input logic [NREQ-1:0] mask, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic clear_inputs();
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
    endtask

    task automatic do_reset(input bit check_state);
        @(negedge pclk);
        clear_inputs();
        prst = 1'b0;
        req_valid = '1;
        #1;
        if (check_state) begin
            check_eq("rst_ctl", {psel, penable, pwrite, rsp_err}, 4'b0000);
            check_eq("rst_paddr", paddr, 0);
            check_eq("rst_pwdata", pwdata, 0);
            check_eq("rst_rsp", {rsp_valid, req_ready}, 0);
            check_eq("rst_rdata", rsp_rdata, 0);
        end
        repeat (2) @(negedge pclk);
        req_valid = '0;
        prst = 1'b1;
        last_gnt = NREQ - 1;
    endtask

    // One isolated transfer: offer mask, observe the grant, serve it with a given wait.
    task automatic run_xfer(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] wr_mask,
                            input int wait_n, input bit err, input logic [DW-1:0] rdata,
                            input bit use_fix, input logic [AW-1:0] fix_addr,
                            input logic [DW-1:0] fix_data);
        int w, n_acc;
        bit tmo, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge pclk);
        req_valid = mask;
        req_write = wr_mask;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = use_fix ? fix_addr : ($urandom & 32'hFFFF_FFFC);
            req_wdata[i*DW +: DW] = use_fix ? fix_data : $urandom;
        end
        pready = 1'b0; pslverr = 1'b0;
        #1;
        w = rr_pick(mask, last_gnt);
        check_eq("grant", req_ready, oh(w));
        ea = req_addr[w*AW +: AW];
        ew = wr_mask[w];
        ed = ew ? req_wdata[w*DW +: DW] : '0;
        last_gnt = w;

        @(negedge pclk);
        req_valid = '0;
        #1;
        check_eq("setup_ctl", {psel, penable, pwrite}, {2'b10, ew});
        check_eq("setup_addr", paddr, ea);
        check_eq("setup_wdata", pwdata, ed);

        tmo   = (TIMEOUT != 0) && (wait_n >= TIMEOUT);
        n_acc = tmo ? TIMEOUT : wait_n + 1;
        for (int c = 0; c < n_acc; c++) begin
            @(negedge pclk);
            pready  = !tmo && (c == wait_n);
            pslverr = pready ? err : 1'($urandom);
            prdata  = pready ? rdata : $urandom;
            #1;
            check_eq("acc_ctl", {psel, penable, rsp_valid}, {2'b11, {NREQ{1'b0}}});
            check_eq("acc_bus", {paddr, pwdata}, {ea, ed});
        end

        @(negedge pclk);
        pready = 1'b0; pslverr = 1'b0;
        #1;
        check_eq("rsp_valid", rsp_valid, oh(w));
        check_eq("rsp_err", rsp_err, tmo ? 1'b1 : err);
        check_eq("rsp_rdata", rsp_rdata, (tmo || ew) ? '0 : rdata);
        check_eq("end_bus", {psel, penable}, 2'b00);
    endtask

    // All requesters valid continuously with a zero-wait slave.
    task automatic run_b2b();
        int exp_w;
        int q[$];
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = 32'h100 + 32'(i * 4);
            req_wdata[i*DW +: DW] = $urandom;
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge pclk);
            req_valid = (c < 10) ? '1 : '0;
            req_write = '1;
            pready = 1'b1; pslverr = 1'b0;
            prdata = $urandom;
            #1;
            if (c < 10 && c % 2 == 0) begin
                exp_w = rr_pick('1, last_gnt);
                check_eq("b2b_grant", req_ready, oh(exp_w));
                last_gnt = exp_w;
                q.push_back(exp_w);
            end else begin
                check_eq("b2b_noready", req_ready, 0);
            end
            if (c >= 1 && c <= 10) check_eq("b2b_psel", psel, 1'b1);
            if (c == 11) check_eq("b2b_idle", psel, 1'b0);
            if (c >= 3 && c % 2 == 1) begin
                check_eq("b2b_rsp", rsp_valid, oh(q.pop_front()));
                check_eq("b2b_rdata", rsp_rdata, 0);
            end
        end
        pready = 1'b0;
    endtask

    task automatic run_mid_reset();
        @(negedge pclk);
        req_valid = 4'b0100;
        req_write = '0;
        for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = 32'h200 + 32'(i * 16);
        pready = 1'b0;
        @(negedge pclk);
        req_valid = '0;
        repeat (3) @(negedge pclk);
        prst = 1'b0;
        req_valid = '1;
        #1;
        check_eq("mrst_ctl", {psel, penable, pwrite}, 3'b000);
        check_eq("mrst_bus", {paddr, pwdata}, 0);
        check_eq("mrst_hs", {req_ready, rsp_valid}, 0);
        @(negedge pclk);
        prst = 1'b1;
        last_gnt = NREQ - 1;
        #1;
        check_eq("mrst_first", req_ready, oh(rr_pick('1, last_gnt)));
        last_gnt = rr_pick('1, last_gnt);
        @(negedge pclk);
        req_valid = '0;
        #1;
        check_eq("mrst_addr", paddr, req_addr[last_gnt*AW +: AW]);
        @(negedge pclk);
        pready = 1'b1;
        prdata = 32'h1234_5678;
        @(negedge pclk);
        pready = 1'b0;
        #1;
        check_eq("mrst_rsp", rsp_valid, oh(last_gnt));
        check_eq("mrst_rdata", rsp_rdata, 32'h1234_5678);
    endtask

    initial begin
        int r, wt;
        prst = 1'b1;
        clear_inputs();
        do_reset(1'b1);

        run_xfer(4'b0001, 4'b0000, 0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h10, 32'h0);
        do_reset(1'b0);
        run_b2b();
        run_xfer(4'b0100, 4'b0100, 3, 1'b0, 32'h0BAD_F00D, 1'b1, 32'h44, 32'hA5A5_A5A5);
        run_xfer(4'b0010, 4'b0000, 1, 1'b1, 32'hCAFE_0001, 1'b0, '0, '0);
        run_xfer(4'b0001, 4'b0000, TIMEOUT + 4, 1'b0, 32'hFFFF_FFFF, 1'b0, '0, '0);
        run_xfer(4'b1000, 4'b0000, TIMEOUT - 1, 1'b0, 32'h5555_AAAA, 1'b0, '0, '0);

        for (int t = 0; t < 40; t++) begin
            r  = $urandom_range(0, 9);
            wt = (r < 7) ? (r % 4) : ((r == 7) ? TIMEOUT - 1 : TIMEOUT + 2);
            run_xfer(4'($urandom_range(1, 15)), 4'($urandom), wt,
                     ($urandom_range(0, 3) == 0), $urandom, 1'b0, '0, '0);
        end

        run_mid_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
